// File: rtl/z_buffer_stage_pkg.sv
// Shared types and pixel field helpers for the depth-test stage.
// Field helpers take widths as arguments so parameterised instances can share them.
package zbuffer_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    CMP
  } state_t;

  localparam int unsigned Z_WIDTH_DEF = 5;
  localparam logic [Z_WIDTH_DEF-1:0] Z_MAX = '1;

  function automatic logic [31:0] pix_field(input logic [31:0] pix,
                                            input int unsigned lsb,
                                            input int unsigned width);
    return (pix >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Pixel layout is {addr, z, colour} with colour in the LSBs.
  function automatic logic [31:0] pix_addr(input logic [31:0] pix, input int unsigned aw,
                                           input int unsigned zw, input int unsigned cw);
    return pix_field(pix, zw + cw, aw);
  endfunction

  function automatic logic [31:0] pix_z(input logic [31:0] pix, input int unsigned zw,
                                        input int unsigned cw);
    return pix_field(pix, cw, zw);
  endfunction

  function automatic logic [31:0] pix_color(input logic [31:0] pix, input int unsigned cw);
    return pix_field(pix, 0, cw);
  endfunction

endpackage

// File: rtl/z_buffer_stage_if.sv
// Pixel handshake from the contention-tree merger into the depth-test stage.
interface z_buffer_stage_if #(
  parameter int unsigned PIXEL_WIDTH = 16
);
  logic [PIXEL_WIDTH-1:0] pix_in;
  logic                   send_z_buffer;
  logic                   rdy_z_buffer;

  modport master (output pix_in, output send_z_buffer, input rdy_z_buffer);
  modport slave  (input pix_in, input send_z_buffer, output rdy_z_buffer);
endinterface

// File: rtl/z_buffer_stage_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; array contents are cleared by the owner's sweep.
module zbuf_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rdata <= '0;
    else        o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/z_buffer_stage.sv
// Depth-test stage: accepts a pixel, compares against stored depth, writes closer pixels,
// sweeps both memories clear after reset or on request, and serves a display colour port.
module z_buffer_stage
  import zbuffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned Z_WIDTH     = 5,
  parameter int unsigned COLOR_WIDTH = 5,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  z_buffer_stage_if.slave        pix_if,
  input  logic                   clear_req,
  input  logic [ADDR_WIDTH-1:0]  disp_addr,
  output logic [COLOR_WIDTH-1:0] disp_color,
  output logic                   clearing,
  output logic [CNT_WIDTH-1:0]   n_written
);

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_clr_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [Z_WIDTH-1:0]     r_z;
  logic [COLOR_WIDTH-1:0] r_color;
  logic                   r_pend;
  logic [CNT_WIDTH-1:0]   r_n_written;

  logic [PIXEL_WIDTH-1:0] w_pix;
  logic [ADDR_WIDTH-1:0]  w_in_addr;
  logic [Z_WIDTH-1:0]     w_in_z;
  logic [COLOR_WIDTH-1:0] w_in_color;
  logic [Z_WIDTH-1:0]     w_z_mem;
  logic                   w_xfer;
  logic                   w_closer;
  logic                   w_we;
  logic [ADDR_WIDTH-1:0]  w_waddr;
  logic [Z_WIDTH-1:0]     w_wz;
  logic [COLOR_WIDTH-1:0] w_wcolor;

  assign w_pix      = pix_if.pix_in;
  assign w_in_addr  = ADDR_WIDTH'(pix_addr(32'(w_pix), ADDR_WIDTH, Z_WIDTH, COLOR_WIDTH));
  assign w_in_z     = Z_WIDTH'(pix_z(32'(w_pix), Z_WIDTH, COLOR_WIDTH));
  assign w_in_color = COLOR_WIDTH'(pix_color(32'(w_pix), COLOR_WIDTH));

  assign pix_if.rdy_z_buffer = (r_state == IDLE);
  assign clearing            = (r_state == CLEAR);
  assign n_written           = r_n_written;

  assign w_xfer   = pix_if.send_z_buffer && (r_state == IDLE);
  // Stored depth is at most all-ones, so a strict compare also rejects z == Z_MAX.
  assign w_closer = (r_z < w_z_mem);

  always_comb begin
    w_we     = 1'b0;
    w_waddr  = r_addr;
    w_wz     = r_z;
    w_wcolor = r_color;
    case (r_state)
      CLEAR: begin
        w_we     = 1'b1;
        w_waddr  = r_clr_cnt;
        w_wz     = '1;
        w_wcolor = '0;
      end
      CMP:     w_we = w_closer;
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_pend      <= 1'b0;
      r_n_written <= '0;
      r_addr      <= '0;
      r_z         <= '0;
      r_color     <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == '1) r_state <= IDLE;
        end
        IDLE: begin
          if (w_xfer) begin
            r_addr  <= w_in_addr;
            r_z     <= w_in_z;
            r_color <= w_in_color;
            if (clear_req) r_pend <= 1'b1;
            r_state <= CMP;
          end else if (r_pend || clear_req) begin
            r_clr_cnt   <= '0;
            r_pend      <= 1'b0;
            r_n_written <= '0;
            r_state     <= CLEAR;
          end
        end
        CMP: begin
          if (clear_req) r_pend <= 1'b1;
          if (w_closer && (r_n_written != '1)) r_n_written <= r_n_written + CNT_WIDTH'(1);
          r_state <= IDLE;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Depth read address follows pix_in so the value is ready in CMP after a transfer edge.
  zbuf_ram #(.AW(ADDR_WIDTH), .DW(Z_WIDTH)) u_depth_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wz),
    .i_raddr (w_in_addr),
    .o_rdata (w_z_mem)
  );

  zbuf_ram #(.AW(ADDR_WIDTH), .DW(COLOR_WIDTH)) u_color_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wcolor),
    .i_raddr (disp_addr),
    .o_rdata (disp_color)
  );

endmodule

// File: tb/tb_z_buffer_stage.sv
// Scoreboard bench for z_buffer_stage: a driver updates an array-based model and queues
// expected n_written / display colours; a monitor pops and compares on DUT responses.
module tb_z_buffer_stage;

  localparam int AW = 6, ZW = 5, CW = 5, PW = 16, NW = 16, DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic [AW-1:0] disp_addr;
  logic [CW-1:0] disp_color;
  logic          clearing;
  logic [NW-1:0] n_written;
  logic          disp_req;

  z_buffer_stage_if #(.PIXEL_WIDTH(PW)) u_if ();

  z_buffer_stage #(
    .ADDR_WIDTH(AW), .Z_WIDTH(ZW), .COLOR_WIDTH(CW), .PIXEL_WIDTH(PW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .reset(reset), .pix_if(u_if), .clear_req(clear_req),
    .disp_addr(disp_addr), .disp_color(disp_color), .clearing(clearing), .n_written(n_written)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_z [DEPTH];
  int m_c [DEPTH];
  int m_cnt;
  int q_cnt [$];
  int q_col [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_z[i] = 31;
      m_c[i] = 0;
    end
    m_cnt = 0;
  endfunction

  // Depth test rule: strictly smaller z wins; count saturates at all-ones.
  function automatic void model_pixel(input int a, input int z, input int c);
    if (z < m_z[a]) begin
      m_z[a] = z;
      m_c[a] = c;
      if (m_cnt != 65535) m_cnt++;
    end
  endfunction

  // Monitor: handshake seen at a negedge -> n_written settles two negedges later.
  initial begin
    bit hs1 = 0, hs2 = 0, dr = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hs1 = 0; hs2 = 0; dr = 0;
      end else begin
        if (dr) begin
          if (q_col.size() == 0) begin
            checks++; errors++;
            $display("FAIL disp_color: actual %0d required none (queue empty)", disp_color);
          end else check("disp_color", disp_color, q_col.pop_front());
        end
        if (hs2) begin
          if (q_cnt.size() == 0) begin
            checks++; errors++;
            $display("FAIL n_written: actual %0d required none (queue empty)", n_written);
          end else check("n_written", n_written, q_cnt.pop_front());
        end
        hs2 = hs1;
        hs1 = u_if.send_z_buffer && u_if.rdy_z_buffer;
        dr  = disp_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int a, input int z, input int c, input bit clr_in_cmp,
                          output int unsigned acc_cyc);
    bit ok = 0;
    u_if.pix_in        = {AW'(a), ZW'(z), CW'(c)};
    u_if.send_z_buffer = 1'b1;
    acc_cyc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = u_if.rdy_z_buffer;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: actual not accepted required accepted (addr %0d)", a);
      u_if.send_z_buffer = 1'b0;
      tick();
    end else begin
      acc_cyc = cyc;
      model_pixel(a, z, c);
      q_cnt.push_back(m_cnt);
      tick();
      if (clr_in_cmp) begin
        clear_req          = 1'b1;
        u_if.send_z_buffer = 1'b0;
      end
      @(negedge clk);
      check("rdy_in_cmp", u_if.rdy_z_buffer, 0);
      tick();
      clear_req = 1'b0;
    end
  endtask

  task automatic go_idle();
    u_if.send_z_buffer = 1'b0;
    tick();
    tick();
  endtask

  task automatic disp_sweep();
    for (int a = 0; a < DEPTH; a++) begin
      disp_addr = AW'(a);
      disp_req  = 1'b1;
      q_col.push_back(m_c[a]);
      tick();
    end
    disp_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic disp_one(input int a);
    disp_addr = AW'(a);
    disp_req  = 1'b1;
    q_col.push_back(m_c[a]);
    tick();
    disp_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic measure_clear(input string name);
    bit seen = 0;
    int n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = clearing;
    end
    check({name, "_rdy_low"}, u_if.rdy_z_buffer, 0);
    while (clearing && n < 300) begin
      n++;
      @(negedge clk);
    end
    check({name, "_len"}, n, 64);
    check({name, "_rdy_after"}, u_if.rdy_z_buffer, 1);
    check({name, "_n_written"}, n_written, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc, first_acc, last_acc;
    reset = 1'b0; clear_req = 1'b0; disp_addr = '0; disp_req = 1'b0;
    u_if.pix_in = '0; u_if.send_z_buffer = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_clearing", clearing, 1);
    check("reset_rdy", u_if.rdy_z_buffer, 0);
    check("reset_n_written", n_written, 0);
    check("reset_disp_color", disp_color, 0);
    tick();
    reset = 1'b1;
    measure_clear("clear_after_reset");
    disp_sweep();

    // Single write, then overwrite rules at the same address.
    send_pix(5, 10, 7, 0, acc);
    go_idle();
    disp_one(5);
    send_pix(5, 12, 3, 0, acc);
    send_pix(5, 10, 4, 0, acc);
    send_pix(5, 9, 2, 0, acc);
    go_idle();
    disp_one(5);
    check("t3_n_written", n_written, 2);

    // Back-to-back with send held high: one accept every two cycles.
    send_pix(10, 20, 1, 0, first_acc);
    for (int i = 1; i < 5; i++) send_pix(10 + i, 20 - i, 1 + i, 0, acc);
    send_pix(15, 3, 30, 0, last_acc);
    check("t4_accept_span", last_acc - first_acc, 10);
    go_idle();
    disp_sweep();

    for (int i = 0; i < 200; i++) begin
      send_pix($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31), 0, acc);
      if ($urandom_range(0, 2) == 0) begin
        u_if.send_z_buffer = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    go_idle();
    disp_sweep();

    // Clear request during CMP: pixel completes, then sweep.
    send_pix(20, 3, 9, 1, acc);
    model_clear();
    measure_clear("clear_from_cmp");
    disp_sweep();

    for (int i = 0; i < 20; i++)
      send_pix($urandom_range(30, 40), $urandom_range(0, 31), $urandom_range(0, 31), 0, acc);
    go_idle();
    disp_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_clear();
    measure_clear("clear_from_idle");
    disp_sweep();

    // Reset while a closer pixel is in CMP.
    u_if.pix_in        = {AW'(7), ZW'(1), CW'(5)};
    u_if.send_z_buffer = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = u_if.rdy_z_buffer;
      end
      check("t6_accepted", ok, 1);
    end
    tick();
    reset = 1'b0;
    u_if.send_z_buffer = 1'b0;
    model_clear();
    @(negedge clk);
    check("t6_reset_clearing", clearing, 1);
    check("t6_reset_n_written", n_written, 0);
    check("t6_reset_disp_color", disp_color, 0);
    tick();
    reset = 1'b1;
    measure_clear("clear_after_midreset");
    check("t6_n_after", n_written, 0);
    disp_sweep();

    repeat (4) tick();
    check("q_cnt_drained", q_cnt.size(), 0);
    check("q_col_drained", q_col.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
